i2s_sample_feeder: RTL

I2S slave receiver and sample buffer that feeds the S/PDIF transmitter. It deserialises a 16-bit stereo I2S stream into `{right[15:0], left[15:0]}` words and buffers them in a small FIFO. It presents the FIFO head to the transmitter's `sample_i`, popping one word on each `sample_req_o` pulse from the transmitter. I2S pins are asynchronous to `clk_i` and are synchronised internally.

---
 rtl/i2s_sample_feeder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/i2s_sample_feeder.sv
// I2S slave receiver (16-bit stereo) feeding a first-word-fall-through sample FIFO.
// Optional macro I2S_FEEDER_HOLD_LAST_EN: repeat the last popped word while empty instead of muting.
module i2s_sample_feeder #(
   parameter int DEPTH = 8,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          i2s_bclk_i,
   input  logic          i2s_lrclk_i,
   input  logic          i2s_sdata_i,
   output logic [31:0]   sample_o,
   input  logic          sample_req_i,
   output logic          valid_o,
   output logic [LW-1:0] level_o,
   output logic          overflow_o,
   output logic          underrun_o,
   input  logic          clr_err_i
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   logic [1:0]    bclk_sync, lr_sync, sd_sync;
   logic          bclk_hist;
   logic          bclk_rise, lr_now, sd_now;

   logic [4:0]    bit_cnt;
   logic          lr_q;
   logic [15:0]   shift_q, left_q;
   logic          left_ok;
   logic          ch_change, data_bit, last_bit, push;
   logic [15:0]   shift_next;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] count_q;
   logic          empty, full, pop_ok, wr_ok, overflow_ev, underrun_ev;
   logic          overflow_q, underrun_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bclk_sync <= '0;
         lr_sync   <= '0;
         sd_sync   <= '0;
         bclk_hist <= 1'b0;
      end else begin
         bclk_sync <= {bclk_sync[0], i2s_bclk_i};
         lr_sync   <= {lr_sync[0], i2s_lrclk_i};
         sd_sync   <= {sd_sync[0], i2s_sdata_i};
         bclk_hist <= bclk_sync[1];
      end
   end

   assign bclk_rise = bclk_sync[1] & ~bclk_hist;
   assign lr_now    = lr_sync[1];
   assign sd_now    = sd_sync[1];

   // bit_cnt holds the index of the last bit seen in this channel; 0 is the delay bit.
   always_comb begin
      ch_change  = bclk_rise && (lr_now != lr_q);
      data_bit   = bclk_rise && !ch_change && (bit_cnt < 5'd16);
      last_bit   = data_bit && (bit_cnt == 5'd15);
      shift_next = {shift_q[14:0], sd_now};
      push       = last_bit && lr_q && left_ok;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         bit_cnt <= '0;
         lr_q    <= 1'b0;
         shift_q <= '0;
         left_q  <= '0;
         left_ok <= 1'b0;
      end else begin
         if (ch_change) begin
            lr_q    <= lr_now;
            bit_cnt <= '0;
         end else if (bclk_rise && (bit_cnt != 5'd17)) begin
            bit_cnt <= bit_cnt + 5'd1;
         end
         if (data_bit) shift_q <= shift_next;
         if (last_bit && !lr_q) begin
            left_q  <= shift_next;
            left_ok <= 1'b1;
         end else if (last_bit && lr_q) begin
            left_ok <= 1'b0;
         end
      end
   end

   // Consumer handshake: a word is taken on the edge where sample_req_i=1 and valid_o=1;
   // a request while valid_o=0 takes nothing and raises underrun_o.
   always_comb begin
      empty       = (count_q == '0);
      full        = (count_q == FULL_LVL);
      pop_ok      = sample_req_i && !empty;
      wr_ok       = push && (!full || pop_ok);
      overflow_ev = push && full && !pop_ok;
      underrun_ev = sample_req_i && empty;
   end

   always_ff @(posedge clk_i) begin
      if (wr_ok) mem[wr_ptr] <= {shift_next, left_q};
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         if (wr_ok)  wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_ok, pop_ok})
            2'b10:   count_q <= count_q + LW'(1);
            2'b01:   count_q <= count_q - LW'(1);
            default: count_q <= count_q;
         endcase
         // A new error event in the same cycle as a clear leaves the flag set.
         overflow_q <= overflow_ev | (overflow_q & ~clr_err_i);
         underrun_q <= underrun_ev | (underrun_q & ~clr_err_i);
      end
   end

`ifdef I2S_FEEDER_HOLD_LAST_EN
   logic [31:0] last_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)      last_q <= '0;
      else if (pop_ok) last_q <= mem[rd_ptr];
   end

   assign sample_o = empty ? last_q : mem[rd_ptr];
`else
   assign sample_o = empty ? 32'h0000_0000 : mem[rd_ptr];
`endif

   assign valid_o    = !empty;
   assign level_o    = count_q;
   assign overflow_o = overflow_q;
   assign underrun_o = underrun_q;

endmodule
